// File: rtl/rx_brz_dec.sv
// rx_brz_dec: bipolar return-to-zero bit decoder. It recovers bit timing from the
// RXP/RXN leading edges, assembles bytes MSB-first and flags end of packet and errors.
`timescale 1ns/1ps
module rx_brz_dec #(
    parameter int NP = 100
) (
    input  logic       clk,
    input  logic       res,
    input  logic       ce,
    input  logic       RXP,
    input  logic       RXN,
    output logic       BIT,
    output logic       BIT_stb,
    output logic [7:0] DAT,
    output logic       DAT_stb,
    output logic [7:0] BCNT,
    output logic       EOP,
    output logic       ERR,
    output logic       BUSY,
    output logic       MTRP_res
);
    localparam int CW = $clog2(2 * NP);
    localparam int IW = $clog2(NP);
    localparam logic [CW:0]   PH_ONE  = (CW+1)'(1);
    localparam logic [CW:0]   PH_HALF = (CW+1)'(NP / 2);
    localparam logic [CW:0]   PH_LIM  = (CW+1)'(NP + NP / 2);
    localparam logic [IW-1:0] IC_ONE  = IW'(1);
    localparam logic [IW-1:0] IC_LAST = IW'(NP - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t r_state, w_state_nx;

    logic          r_rxp_d, r_rxn_d, r_first;
    logic [CW-1:0] r_cnt;
    logic [IW-1:0] r_icnt;
    logic [6:0]    r_sh;
    logic [2:0]    r_bits;

    logic          w_ep, w_en, w_one, w_both, w_idle;
    logic          w_in_win, w_tout, w_take, w_tout_ev, w_err, w_mtrp, w_byte;
    logic [CW:0]   w_phase;
    logic [2:0]    w_bbase;

    always_ff @(posedge clk) begin
        if (!res) r_state <= S_IDLE;
        else      r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        if (r_state == S_IDLE && w_take)        w_state_nx = S_RUN;
        else if (r_state == S_RUN && w_tout_ev) w_state_nx = S_IDLE;
    end

    // w_phase counts the current tick, so it equals ticks elapsed since the last accepted edge
    always_comb begin
        w_ep      = RXP & ~r_rxp_d;
        w_en      = RXN & ~r_rxn_d;
        w_one     = w_ep ^ w_en;
        w_both    = w_ep & w_en;
        w_idle    = (r_state == S_IDLE);
        w_phase   = {1'b0, r_cnt} + PH_ONE;
        w_in_win  = (w_phase >= PH_HALF);
        w_tout    = (w_phase >= PH_LIM);
        w_take    = ce & w_one & (w_idle | w_in_win);
        w_tout_ev = ce & ~w_idle & ~w_take & w_tout;
        w_err     = ce & (w_both | (~w_idle & w_one & ~w_in_win) |
                          (w_tout_ev & (BCNT[2:0] != 3'd0)));
        w_mtrp    = ce & w_idle & ~w_take & (r_first | (r_icnt == IC_LAST));
        w_bbase   = w_idle ? 3'd0 : r_bits;
        w_byte    = (w_bbase == 3'd7);
        BUSY      = (r_state == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            r_rxp_d  <= 1'b0;
            r_rxn_d  <= 1'b0;
            r_first  <= 1'b1;
            r_cnt    <= '0;
            r_icnt   <= '0;
            r_sh     <= '0;
            r_bits   <= '0;
            BIT      <= 1'b0;
            BIT_stb  <= 1'b0;
            DAT      <= '0;
            DAT_stb  <= 1'b0;
            BCNT     <= '0;
            EOP      <= 1'b0;
            ERR      <= 1'b0;
            MTRP_res <= 1'b0;
        end else begin
            BIT_stb  <= w_take;
            DAT_stb  <= w_take & w_byte;
            EOP      <= w_tout_ev;
            ERR      <= w_err;
            MTRP_res <= w_mtrp;
            if (ce) begin
                r_rxp_d <= RXP;
                r_rxn_d <= RXN;
                r_first <= 1'b0;
                if (w_idle) begin
                    r_cnt  <= '0;
                    r_icnt <= (r_icnt == IC_LAST) ? '0 : r_icnt + IC_ONE;
                end else begin
                    r_icnt <= '0;
                    if (w_take)                r_cnt <= '0;
                    else if (w_phase > PH_LIM) r_cnt <= PH_LIM[CW-1:0];
                    else                       r_cnt <= w_phase[CW-1:0];
                end
                if (w_take) begin
                    BIT    <= w_ep;
                    r_sh   <= {r_sh[5:0], w_ep};
                    r_bits <= w_bbase + 3'd1;
                    if (w_byte) DAT <= {r_sh, w_ep};
                    if (w_idle)              BCNT <= 8'd1;
                    else if (BCNT != 8'hFF)  BCNT <= BCNT + 8'd1;
                end
                if (w_tout_ev) begin
                    r_bits <= '0;
                    if (BCNT[2:0] != 3'd0) r_sh <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_rx_brz_dec.sv
// Self-checking bench for rx_brz_dec: directed packet table, corner sequences and
// randomized pulse trains compared every clock against a tick-level event model.
`timescale 1ns/1ps
module tb_rx_brz_dec;
    localparam int NP  = 100;
    localparam int LIM = NP + NP / 2;

    logic       clk = 1'b0, res = 1'b0, ce = 1'b0, RXP = 1'b0, RXN = 1'b0;
    logic       BIT, BIT_stb, DAT_stb, EOP, ERR, BUSY, MTRP_res;
    logic [7:0] DAT, BCNT;

    rx_brz_dec #(.NP(NP)) dut (
        .clk(clk), .res(res), .ce(ce), .RXP(RXP), .RXN(RXN),
        .BIT(BIT), .BIT_stb(BIT_stb), .DAT(DAT), .DAT_stb(DAT_stb),
        .BCNT(BCNT), .EOP(EOP), .ERR(ERR), .BUSY(BUSY), .MTRP_res(MTRP_res)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         nb;
        logic [7:0] pat;
        int         gap;
        logic [7:0] exp_dat;
        int         exp_dstb;
        int         exp_err;
        int         exp_bcnt;
    } pkt_t;

    int n_cmp = 0, n_bad = 0;

    // reference model state: ticks since packet edge / idle start, bit count, byte value
    int   m_age, m_since, m_nbits, m_acc;
    bit   m_pkt, m_first, m_pd, m_nd;
    logic e_bit, e_bstb, e_dstb, e_eop, e_err, e_busy, e_mtrp;
    logic [7:0] e_dat, e_bcnt;

    int   tick_no = 0, n_bstb = 0, n_dstb = 0, n_eop = 0, n_err = 0, n_mtrp = 0, eop_tick = 0;
    logic [7:0] eop_bcnt = 8'd0;
    int   mtrp_q[$];

    task automatic model_step(input logic r, input logic c, input logic p, input logic n);
        bit ep, en;
        e_bstb = 0; e_dstb = 0; e_eop = 0; e_err = 0; e_mtrp = 0;
        if (!r) begin
            m_pkt = 0; m_age = 0; m_since = 0; m_nbits = 0; m_acc = 0;
            m_first = 1; m_pd = 0; m_nd = 0;
            e_bit = 0; e_dat = 8'd0; e_bcnt = 8'd0; e_busy = 0;
            return;
        end
        if (!c) return;
        ep = p && !m_pd;
        en = n && !m_nd;
        m_pd = p; m_nd = n;
        if (!m_pkt) begin
            m_age++;
            if (ep != en) begin
                m_pkt = 1; m_since = 0; m_nbits = 1; m_acc = int'(ep);
                e_bit = ep; e_bstb = 1; e_bcnt = 8'd1;
            end else begin
                if (ep && en) e_err = 1;
                e_mtrp = m_first || (m_age % NP == 0);
            end
            m_first = 0;
        end else begin
            m_since++;
            if (ep != en && m_since >= NP / 2) begin
                m_since = 0; m_nbits++;
                m_acc = (m_acc * 2 + int'(ep)) % 256;
                e_bit = ep; e_bstb = 1;
                e_bcnt = (m_nbits > 255) ? 8'd255 : 8'(m_nbits);
                if (m_nbits % 8 == 0) begin
                    e_dat = 8'(m_acc); e_dstb = 1;
                end
            end else begin
                if (ep || en) e_err = 1;
                if (m_since >= LIM) begin
                    e_eop = 1; m_pkt = 0; m_age = 0;
                    if (e_bcnt % 8 != 0) e_err = 1;
                end
            end
        end
        e_busy = m_pkt;
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic cyc(input logic r, input logic c, input logic p, input logic n);
        logic [22:0] act_v, exp_v;
        res = r; ce = c; RXP = p; RXN = n;
        model_step(r, c, p, n);
        if (r && c) tick_no++;
        @(posedge clk);
        #1;
        act_v = {BIT, BIT_stb, DAT, DAT_stb, BCNT, EOP, ERR, BUSY, MTRP_res};
        exp_v = {e_bit, e_bstb, e_dat, e_dstb, e_bcnt, e_eop, e_err, e_busy, e_mtrp};
        n_cmp++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL outputs tick %0d t=%0t: got %h expected %h", tick_no, $time, act_v, exp_v);
        end
        if (BIT_stb)  n_bstb++;
        if (DAT_stb)  n_dstb++;
        if (ERR)      n_err++;
        if (EOP) begin
            n_eop++; eop_tick = tick_no; eop_bcnt = BCNT;
        end
        if (MTRP_res) begin
            n_mtrp++; mtrp_q.push_back(tick_no);
        end
        @(negedge clk);
    endtask

    task automatic idle_ticks(input int k);
        for (int i = 0; i < k; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic pulse(input logic pol, input int gap);
        for (int i = 0; i < gap; i++) cyc(1'b1, 1'b1, pol && (i < 5), !pol && (i < 5));
    endtask

    task automatic wait_eop(input int q0);
        int g;
        g = 0;
        while (n_eop == q0 && g < 400) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            g++;
        end
    endtask

    task automatic run_pkt(input string nm, input pkt_t pk);
        int b0, d0, e0, q0, t_last;
        logic [7:0] pv;
        b0 = n_bstb; d0 = n_dstb; e0 = n_err; q0 = n_eop; t_last = 0;
        pv = pk.pat;
        for (int i = 0; i < pk.nb; i++) begin
            t_last = tick_no + 1;
            pulse(pv[7-i], pk.gap);
        end
        wait_eop(q0);
        chk({nm, "_eop_seen"},    n_eop - q0, 1);
        chk({nm, "_eop_latency"}, eop_tick - t_last, LIM);
        chk({nm, "_bitstb"},      n_bstb - b0, pk.nb);
        chk({nm, "_datstb"},      n_dstb - d0, pk.exp_dstb);
        chk({nm, "_err"},         n_err - e0, pk.exp_err);
        chk({nm, "_bcnt"},        int'(eop_bcnt), pk.exp_bcnt);
        chk({nm, "_dat"},         int'(DAT), int'(pk.exp_dat));
        chk({nm, "_busy"},        int'(BUSY), 0);
    endtask

    pkt_t tbl[5];
    pkt_t fresh;
    int   b0, d0, e0, q0, cd, w, sel;
    bit   pp, nn, cr;

    initial begin
        tbl[0] = '{nb:8, pat:8'hB2, gap:100, exp_dat:8'hB2, exp_dstb:1, exp_err:0, exp_bcnt:8};
        tbl[1] = '{nb:5, pat:8'hB0, gap:100, exp_dat:8'hB2, exp_dstb:0, exp_err:1, exp_bcnt:5};
        tbl[2] = '{nb:8, pat:8'h5A, gap:50,  exp_dat:8'h5A, exp_dstb:1, exp_err:0, exp_bcnt:8};
        tbl[3] = '{nb:8, pat:8'hC3, gap:149, exp_dat:8'hC3, exp_dstb:1, exp_err:0, exp_bcnt:8};
        tbl[4] = '{nb:1, pat:8'h80, gap:100, exp_dat:8'hC3, exp_dstb:0, exp_err:1, exp_bcnt:1};
        fresh  = '{nb:8, pat:8'h3C, gap:100, exp_dat:8'h3C, exp_dstb:1, exp_err:0, exp_bcnt:8};

        @(negedge clk);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("reset_outputs", int'({BIT, BIT_stb, DAT, DAT_stb, BCNT, EOP, ERR, BUSY, MTRP_res}), 0);

        // idle after reset: re-latch strobe at ticks 1, 100, 200 and nothing else
        tick_no = 0; mtrp_q.delete();
        b0 = n_bstb; d0 = n_dstb; e0 = n_err; q0 = n_eop;
        idle_ticks(250);
        chk("idle_mtrp_count", mtrp_q.size(), 3);
        chk("idle_mtrp_t0", (mtrp_q.size() > 0) ? mtrp_q[0] : -1, 1);
        chk("idle_mtrp_t1", (mtrp_q.size() > 1) ? mtrp_q[1] : -1, 100);
        chk("idle_mtrp_t2", (mtrp_q.size() > 2) ? mtrp_q[2] : -1, 200);
        chk("idle_other_strobes", (n_bstb - b0) + (n_dstb - d0) + (n_err - e0) + (n_eop - q0), 0);

        for (int i = 0; i < 5; i++) begin
            idle_ticks(20);
            run_pkt($sformatf("pkt%0d", i), tbl[i]);
        end

        // early edge at 30 ticks is rejected; following edge 100 ticks after the accepted one counts
        idle_ticks(20);
        b0 = n_bstb; e0 = n_err; q0 = n_eop;
        pulse(1'b1, 100);
        pulse(1'b0, 30);
        pulse(1'b1, 70);
        chk("early_err", n_err - e0, 1);
        chk("early_bcnt", int'(BCNT), 2);
        pulse(1'b1, 100);
        chk("early_next_bcnt", int'(BCNT), 3);
        wait_eop(q0);
        chk("early_eop_seen", n_eop - q0, 1);
        chk("early_total_err", n_err - e0, 2);
        chk("early_bitstb", n_bstb - b0, 3);
        chk("early_eop_bcnt", int'(eop_bcnt), 3);

        // coincident edges in IDLE
        idle_ticks(10);
        b0 = n_bstb; e0 = n_err;
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("both_err", int'(ERR), 1);
        chk("both_busy", int'(BUSY), 0);
        idle_ticks(10);
        chk("both_bitstb", n_bstb - b0, 0);
        chk("both_err_count", n_err - e0, 1);
        chk("both_busy_after", int'(BUSY), 0);

        // reset in the middle of a packet
        idle_ticks(10);
        q0 = n_eop;
        pulse(1'b1, 100); pulse(1'b0, 100); pulse(1'b1, 100); pulse(1'b0, 50);
        chk("mid_busy", int'(BUSY), 1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("midrst_outputs", int'({BIT, BIT_stb, DAT, DAT_stb, BCNT, EOP, ERR, BUSY, MTRP_res}), 0);
        tick_no = 0;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("midrst_mtrp", int'(MTRP_res), 1);
        idle_ticks(200);
        chk("midrst_no_eop", n_eop - q0, 0);
        run_pkt("fresh", fresh);

        // randomized pulse trains with irregular ce
        cd = 10; w = 0; pp = 0; nn = 0;
        for (int k = 0; k < 8000; k++) begin
            cr = ($urandom_range(0, 3) != 0);
            if (w == 0 && cd == 0) begin
                sel = $urandom_range(0, 19);
                pp = (sel == 0) || (sel % 2 == 1);
                nn = (sel == 0) || (sel % 2 == 0);
                w = 3;
                cd = $urandom_range(25, 210);
            end
            cyc(1'b1, cr, (w > 0) && pp, (w > 0) && nn);
            if (w > 0) w--;
            else if (cd > 0) cd--;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule
